// File: rtl/speed_meter.sv
// ---------------------------------------------------------------------------
// speed_meter
//
// Measures encoder speed. The raw encoder input is synchronised into the clk
// domain and then debounced. Every debounced rising edge inside a fixed gate
// window of GATE_CYCLES clocks is counted. When a window closes, the count is
// published on speed together with a one-cycle done pulse. The next window
// starts on the following cycle with no gap.
//
// Parameters
//   WIDTH_SPEED  width of speed; the count saturates at 2^WIDTH_SPEED-1
//   GATE_CYCLES  clk cycles per measurement window (>= 4)
//   SYNC_STAGES  flops in the enc_in synchroniser (>= 2)
//   FILTER_LEN   consecutive equal samples needed to change the filtered
//                level (>= 1)
//
// Ports
//   clk      in   1            system clock
//   reset_n  in   1            asynchronous reset, active-low
//   enable   in   1            run measurement; low = idle, counters clear
//   enc_in   in   1            raw encoder pulse, asynchronous to clk
//   speed    out  WIDTH_SPEED  edge count of the last completed window
//   done     out  1            1-cycle pulse: speed and ovf updated
//   ovf      out  1            last completed window saturated
// ---------------------------------------------------------------------------
module speed_meter #(
    parameter int WIDTH_SPEED = 14,
    parameter int GATE_CYCLES = 1000000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   enc_in,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   done,
    output logic                   ovf
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int RUN_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [RUN_W-1:0]       RUN_LAST  = RUN_W'(FILTER_LEN - 1);
    localparam logic [WIDTH_SPEED-1:0] SPEED_MAX = '1;

    // Parameter legality, rejected at elaboration time.
    generate
        if (GATE_CYCLES < 4) begin : g_bad_gate
            $error("speed_meter: GATE_CYCLES must be >= 4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("speed_meter: SYNC_STAGES must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter
            $error("speed_meter: FILTER_LEN must be >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Input path state
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    logic                   filt_q, filt_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   rise_q, rise_d;

    // Measurement state
    state_t                 state_q, state_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [WIDTH_SPEED-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                   sat_q, sat_d;
    logic [WIDTH_SPEED-1:0] speed_q, speed_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   terminal;
    logic                   at_max;

    // -----------------------------------------------------------------------
    // Synchroniser: enc_in shifts in at bit 0, the oldest sample is used.
    // -----------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], enc_in};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Debounce filter. run_q counts consecutive samples that disagree with
    // the filtered level; any agreeing sample clears it. When the run reaches
    // FILTER_LEN the level flips. rise_q is a registered one-cycle pulse on
    // a 0->1 flip, so it appears SYNC_STAGES+FILTER_LEN clocks after a clean
    // enc_in edge. The filter runs regardless of enable so that its state
    // is preserved across idle periods.
    // -----------------------------------------------------------------------
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        rise_d = 1'b0;
        if (synced != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = ~filt_q;
                rise_d = ~filt_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign terminal = (gate_cnt_q == GATE_LAST);
    assign at_max   = (pulse_cnt_q == SPEED_MAX);

    // -----------------------------------------------------------------------
    // FSM outputs and window datapath. Counters clear by default, so idle,
    // an enable drop (which wins over a terminal cycle) and window closure
    // all restart from zero. On the terminal cycle a rise present in that
    // same cycle is folded into the published count, and an overflow caused
    // by it is reflected in ovf.
    // -----------------------------------------------------------------------
    always_comb begin
        gate_cnt_d  = '0;
        pulse_cnt_d = '0;
        sat_d       = 1'b0;
        speed_d     = speed_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        if ((state_q == RUN) && enable) begin
            if (terminal) begin
                if (rise_q && !at_max) begin
                    speed_d = pulse_cnt_q + WIDTH_SPEED'(1);
                end else begin
                    speed_d = pulse_cnt_q;
                end
                ovf_d  = sat_q | (rise_q & at_max);
                done_d = 1'b1;
            end else begin
                gate_cnt_d  = gate_cnt_q + GATE_W'(1);
                pulse_cnt_d = pulse_cnt_q;
                sat_d       = sat_q;
                if (rise_q) begin
                    if (at_max) begin
                        sat_d = 1'b1;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + WIDTH_SPEED'(1);
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            run_q       <= '0;
            rise_q      <= 1'b0;
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
            speed_q     <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            run_q       <= run_d;
            rise_q      <= rise_d;
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            sat_q       <= sat_d;
            speed_q     <= speed_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign speed = speed_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_speed_meter.sv
// ---------------------------------------------------------------------------
// tb_speed_meter
//
// Directed bench for speed_meter with GATE_CYCLES=100, FILTER_LEN=2,
// SYNC_STAGES=2. Two instances share all inputs: dut (WIDTH_SPEED=14) and
// dut4 (WIDTH_SPEED=4) for saturation.
//
// Timing reference: after start_run, cycle k (k=1,2,...) is the k-th clock
// after reset release. Window n covers cycles 100*(n-1)+1 .. 100*n, and its
// done pulse is visible in cycle 100*n+1. enc_in driven high in cycle j
// yields a rise in cycle j+4.
// ---------------------------------------------------------------------------
module tb_speed_meter;

    localparam int GATE = 100;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        enc_in  = 1'b0;

    logic [13:0] speed;
    logic        done;
    logic        ovf;
    logic [3:0]  speed4;
    logic        done4;
    logic        ovf4;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    always #5 clk = ~clk;

    speed_meter #(
        .WIDTH_SPEED(14),
        .GATE_CYCLES(GATE),
        .SYNC_STAGES(2),
        .FILTER_LEN (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .enc_in (enc_in),
        .speed  (speed),
        .done   (done),
        .ovf    (ovf)
    );

    speed_meter #(
        .WIDTH_SPEED(4),
        .GATE_CYCLES(GATE),
        .SYNC_STAGES(2),
        .FILTER_LEN (2)
    ) dut4 (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .enc_in (enc_in),
        .speed  (speed4),
        .done   (done4),
        .ovf    (ovf4)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    // Reset both instances, then release with enable high.
    task automatic start_run();
        reset_n = 1'b0;
        enable  = 1'b0;
        enc_in  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        enable  = 1'b1;
        k       = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        enc_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        n_checks++;
        if (speed !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_speed got %0d expected 0", speed);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done got %b expected 0", done);
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ovf got %b expected 0", ovf);
        end
        n_checks++;
        if (speed4 !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_speed4 got %0d expected 0", speed4);
        end
        enc_in = 1'b0;
    endtask

    // Clean 4-high pulses every 10 clocks: 10 per window.
    task automatic test_clean_pulses();
        logic exp_done;
        start_run();
        for (int i = 0; i < 2 * GATE + 1; i++) begin
            step();
            enc_in   = (((k - 1) % 10) < 4);
            exp_done = (k == 101) || (k == 201);
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL clean_done k=%0d got %b expected %b", k, done, exp_done);
            end
            if (exp_done) begin
                n_checks++;
                if (speed !== 14'd10) begin
                    n_fail++;
                    $display("[TB] FAIL clean_speed k=%0d got %0d expected 10", k, speed);
                end
                n_checks++;
                if (ovf !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL clean_ovf k=%0d got %b expected 0", k, ovf);
                end
            end
        end
        enc_in = 1'b0;
    endtask

    // 1-clock glitches every 5 clocks must never pass the filter.
    task automatic test_glitches();
        start_run();
        for (int i = 0; i < 2 * GATE + 1; i++) begin
            step();
            enc_in = (((k - 1) % 5) == 0);
            if ((k == 101) || (k == 201)) begin
                n_checks++;
                if (done !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL glitch_done k=%0d got %b expected 1", k, done);
                end
                n_checks++;
                if (speed !== 14'd0) begin
                    n_fail++;
                    $display("[TB] FAIL glitch_speed k=%0d got %0d expected 0", k, speed);
                end
            end
        end
        enc_in = 1'b0;
    endtask

    // 20 pulses (last rise on the terminal cycle) then 3 pulses.
    task automatic test_saturation();
        logic exp_done;
        start_run();
        for (int i = 0; i < 2 * GATE + 1; i++) begin
            step();
            if (k <= 100) begin
                enc_in = (((k - 1) % 5) < 2);
            end else begin
                enc_in = (k == 101) || (k == 102) || (k == 111) || (k == 112) ||
                         (k == 121) || (k == 122);
            end
            exp_done = (k == 101) || (k == 201);
            n_checks++;
            if (done4 !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL sat_done4 k=%0d got %b expected %b", k, done4, exp_done);
            end
            if (k == 101) begin
                n_checks++;
                if ((speed4 !== 4'd15) || (ovf4 !== 1'b1)) begin
                    n_fail++;
                    $display("[TB] FAIL sat_w1_narrow got speed=%0d ovf=%b expected speed=15 ovf=1",
                             speed4, ovf4);
                end
                n_checks++;
                if ((speed !== 14'd20) || (ovf !== 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL sat_w1_wide got speed=%0d ovf=%b expected speed=20 ovf=0",
                             speed, ovf);
                end
            end
            if (k == 201) begin
                n_checks++;
                if ((speed4 !== 4'd3) || (ovf4 !== 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL sat_w2_narrow got speed=%0d ovf=%b expected speed=3 ovf=0",
                             speed4, ovf4);
                end
                n_checks++;
                if ((speed !== 14'd3) || (ovf !== 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL sat_w2_wide got speed=%0d ovf=%b expected speed=3 ovf=0",
                             speed, ovf);
                end
            end
        end
        enc_in = 1'b0;
    endtask

    // Rises at 100 (terminal, w1), 105 and 154 (w2), 201 (first cycle, w3).
    task automatic test_window_edges();
        logic exp_done;
        start_run();
        for (int i = 0; i < 3 * GATE + 1; i++) begin
            step();
            enc_in = (k == 96) || (k == 97) || (k == 101) || (k == 102) ||
                     (k == 150) || (k == 151) || (k == 197) || (k == 198);
            exp_done = (k == 101) || (k == 201) || (k == 301);
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL edge_done k=%0d got %b expected %b", k, done, exp_done);
            end
            if ((k == 101) && (speed !== 14'd1)) begin
                n_fail++;
                $display("[TB] FAIL edge_terminal k=%0d got %0d expected 1", k, speed);
            end
            if ((k == 201) && (speed !== 14'd2)) begin
                n_fail++;
                $display("[TB] FAIL edge_middle k=%0d got %0d expected 2", k, speed);
            end
            if ((k == 301) && (speed !== 14'd1)) begin
                n_fail++;
                $display("[TB] FAIL edge_first k=%0d got %0d expected 1", k, speed);
            end
            if (exp_done) begin
                n_checks++;
            end
        end
        enc_in = 1'b0;
    endtask

    // Enable drop mid-window discards the partial count; idle pulses ignored.
    task automatic test_enable_drop();
        logic        exp_done;
        logic [13:0] exp_speed;
        start_run();
        for (int i = 0; i < 285; i++) begin
            step();
            if (k <= 150) begin
                enc_in = (((k - 1) % 10) < 4);
            end else if (k < 180) begin
                enc_in = ((k >= 155) && (k <= 158)) || ((k >= 165) && (k <= 168));
            end else begin
                enc_in = ((k >= 190) && (k <= 193)) || ((k >= 200) && (k <= 203)) ||
                         ((k >= 210) && (k <= 213));
            end
            enable    = !((k >= 151) && (k < 180));
            exp_done  = (k == 101) || (k == 281);
            exp_speed = (k >= 281) ? 14'd3 : 14'd10;
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL drop_done k=%0d got %b expected %b", k, done, exp_done);
            end
            if (k >= 101) begin
                n_checks++;
                if ((speed !== exp_speed) || (ovf !== 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL drop_speed k=%0d got speed=%0d ovf=%b expected speed=%0d ovf=0",
                             k, speed, ovf, exp_speed);
                end
            end
        end
        enc_in = 1'b0;
        enable = 1'b1;
    endtask

    // Asynchronous reset mid-window, then a normal first window.
    task automatic test_async_reset();
        logic exp_done;
        start_run();
        for (int i = 0; i < 150; i++) begin
            step();
            enc_in = (((k - 1) % 10) < 4);
        end
        n_checks++;
        if (speed !== 14'd10) begin
            n_fail++;
            $display("[TB] FAIL areset_before got %0d expected 10", speed);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ((speed !== 14'd0) || (done !== 1'b0) || (ovf !== 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL areset_async got speed=%0d done=%b ovf=%b expected all 0",
                     speed, done, ovf);
        end
        enc_in = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        enable  = 1'b1;
        k       = 0;
        for (int i = 0; i < GATE + 1; i++) begin
            step();
            enc_in   = (((k - 1) % 10) < 4);
            exp_done = (k == 101);
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL areset_done k=%0d got %b expected %b", k, done, exp_done);
            end
        end
        n_checks++;
        if (speed !== 14'd10) begin
            n_fail++;
            $display("[TB] FAIL areset_resume got %0d expected 10", speed);
        end
        enc_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_pulses();
        test_glitches();
        test_saturation();
        test_window_edges();
        test_enable_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
